// File: rtl/game_pkg.sv
// Shared game-level definitions: top-level status codes and battle sequencer states.
package game_pkg;

    localparam int HP_W = 4;

    localparam logic [3:0] ST_TITLE  = 4'd1;
    localparam logic [3:0] ST_MAP1   = 4'd2;
    localparam logic [3:0] ST_MAP2   = 4'd3;
    localparam logic [3:0] ST_DIALOG = 4'd4;
    localparam logic [3:0] ST_BATTLE = 4'd5;
    localparam logic [3:0] ST_WIN    = 4'd6;
    localparam logic [3:0] ST_LOSE   = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTRO = 2'd1,
        FIGHT = 2'd2,
        DONE  = 2'd3
    } battle_state_t;

endpackage

// File: rtl/frame_edge.sv
// Rising-edge detector for the vsync-rate frame_clk level; emits a registered one-cycle tick.
module frame_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic prev_q, prev_d;
    logic tick_q, tick_d;

    // Edge compare against the previous sample.
    always_comb begin
        prev_d = frame_clk;
        tick_d = frame_clk & ~prev_q;
    end

    // Previous-value and tick registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/battle_ctrl.sv
// Battle-phase sequencer: battle clock, player HP with invulnerability window, bullet phases.
//
//   state | meaning
//   IDLE  | not in battle; outputs hold, bullets and invuln off
//   INTRO | grace period before bullets start, hits ignored
//   FIGHT | bullets on, damage applied, battle clock running
//   DONE  | battle over (won or HP exhausted); HP and time_up hold
module battle_ctrl
    import game_pkg::*;
#(
    parameter logic [HP_W-1:0] MAX_HP        = 4'd10,
    parameter logic [HP_W-1:0] DAMAGE        = 4'd2,
    parameter int              INTRO_FRAMES  = 60,
    parameter int              BATTLE_FRAMES = 1800,
    parameter int              IFRAMES       = 30,
    parameter int              PHASE_FRAMES  = 450
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [3:0]      status,
    input  logic            frame_clk,
    input  logic            hit,
    output logic [HP_W-1:0] HP,
    output logic            time_up,
    output logic            invuln,
    output logic            bullets_en,
    output logic [1:0]      phase
);

    localparam logic [11:0] INTRO_LAST  = 12'(INTRO_FRAMES);
    localparam logic [11:0] BATTLE_LAST = 12'(BATTLE_FRAMES);
    localparam logic [8:0]  PHASE_LAST  = 9'(PHASE_FRAMES);
    localparam logic [5:0]  IFRAME_LOAD = 6'(IFRAMES);

    battle_state_t   state_q, state_d;
    logic [3:0]      status_prev_q, status_prev_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic            time_up_q, time_up_d;
    logic            invuln_q, invuln_d;
    logic            bullets_en_q, bullets_en_d;
    logic [1:0]      phase_q, phase_d;
    logic [11:0]     frame_cnt_q, frame_cnt_d;
    logic [8:0]      phase_cnt_q, phase_cnt_d;
    logic [5:0]      iframe_q, iframe_d;

    logic            tick;
    logic            entry;
    logic            hit_ok;
    logic [HP_W-1:0] hp_hit;
    logic [11:0]     frame_inc;
    logic [8:0]      phase_inc;

    frame_edge u_frame_edge (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Next-state and registered-output logic; battle entry overrides everything else.
    always_comb begin
        state_d       = state_q;
        status_prev_d = status;
        hp_d          = hp_q;
        time_up_d     = time_up_q;
        phase_d       = phase_q;
        frame_cnt_d   = frame_cnt_q;
        phase_cnt_d   = phase_cnt_q;
        iframe_d      = iframe_q;

        entry     = (status == ST_BATTLE) && (status_prev_q != ST_BATTLE);
        hit_ok    = hit && (iframe_q == 6'd0);
        hp_hit    = (hp_q > DAMAGE) ? (hp_q - DAMAGE) : '0;
        frame_inc = frame_cnt_q + 12'd1;
        phase_inc = phase_cnt_q + 9'd1;

        if (entry) begin
            state_d     = INTRO;
            hp_d        = MAX_HP;
            time_up_d   = 1'b0;
            phase_d     = 2'd0;
            frame_cnt_d = 12'd0;
            phase_cnt_d = 9'd0;
            iframe_d    = 6'd0;
        end else if ((state_q != IDLE) && (status != ST_BATTLE)) begin
            state_d   = IDLE;
            time_up_d = 1'b0;
            iframe_d  = 6'd0;
        end else begin
            case (state_q)
                INTRO: begin
                    if (tick) begin
                        if (frame_inc == INTRO_LAST) begin
                            state_d     = FIGHT;
                            frame_cnt_d = 12'd0;
                        end else begin
                            frame_cnt_d = frame_inc;
                        end
                    end
                end
                FIGHT: begin
                    if (hit_ok) begin
                        hp_d     = hp_hit;
                        iframe_d = IFRAME_LOAD;
                    end else if (tick && (iframe_q != 6'd0)) begin
                        iframe_d = iframe_q - 6'd1;
                    end
                    // A fatal hit freezes the battle clock, even on the final tick.
                    if (hit_ok && (hp_hit == '0)) begin
                        state_d = DONE;
                    end else if (tick) begin
                        frame_cnt_d = frame_inc;
                        if (phase_inc == PHASE_LAST) begin
                            phase_cnt_d = 9'd0;
                            phase_d     = phase_q + 2'd1;
                        end else begin
                            phase_cnt_d = phase_inc;
                        end
                        if (frame_inc == BATTLE_LAST) begin
                            time_up_d = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    if (tick && (iframe_q != 6'd0)) begin
                        iframe_d = iframe_q - 6'd1;
                    end
                end
                default: ;
            endcase
        end

        invuln_d     = (iframe_d != 6'd0);
        bullets_en_d = (state_d == FIGHT);
    end

    // State, counter and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            status_prev_q <= 4'd0;
            hp_q          <= MAX_HP;
            time_up_q     <= 1'b0;
            invuln_q      <= 1'b0;
            bullets_en_q  <= 1'b0;
            phase_q       <= 2'd0;
            frame_cnt_q   <= 12'd0;
            phase_cnt_q   <= 9'd0;
            iframe_q      <= 6'd0;
        end else begin
            state_q       <= state_d;
            status_prev_q <= status_prev_d;
            hp_q          <= hp_d;
            time_up_q     <= time_up_d;
            invuln_q      <= invuln_d;
            bullets_en_q  <= bullets_en_d;
            phase_q       <= phase_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_cnt_q   <= phase_cnt_d;
            iframe_q      <= iframe_d;
        end
    end

    assign HP         = hp_q;
    assign time_up    = time_up_q;
    assign invuln     = invuln_q;
    assign bullets_en = bullets_en_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_battle_ctrl.sv
// Scoreboard bench for battle_ctrl: a behavioural model predicts outputs each cycle,
// a monitor compares them against the DUT, and directed checks pin key spec values.
module tb_battle_ctrl;
    import game_pkg::*;

    localparam int P_MAX    = 10;
    localparam int P_DMG    = 2;
    localparam int P_INTRO  = 60;
    localparam int P_BATTLE = 200;
    localparam int P_IFR    = 30;
    localparam int P_PHASE  = 25;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] status;
    logic       frame_clk;
    logic       hit;
    logic [3:0] HP;
    logic       time_up, invuln, bullets_en;
    logic [1:0] phase;

    always #5 Clk = ~Clk;

    battle_ctrl #(
        .MAX_HP        (4'(P_MAX)),
        .DAMAGE        (4'(P_DMG)),
        .INTRO_FRAMES  (P_INTRO),
        .BATTLE_FRAMES (P_BATTLE),
        .IFRAMES       (P_IFR),
        .PHASE_FRAMES  (P_PHASE)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .status     (status),
        .frame_clk  (frame_clk),
        .hit        (hit),
        .HP         (HP),
        .time_up    (time_up),
        .invuln     (invuln),
        .bullets_en (bullets_en),
        .phase      (phase)
    );

    typedef enum int {M_IDLE, M_INTRO, M_FIGHT, M_DONE} mode_t;
    typedef struct {
        int hp;
        bit tu;
        bit inv;
        bit ben;
        int ph;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    mode_t      m_mode   = M_IDLE;
    int         m_hp     = P_MAX;
    int         m_iframe = 0;
    int         m_intro  = 0;
    int         m_fight  = 0;
    bit         m_tu     = 1'b0;
    bit         m_tick   = 1'b0;
    bit         m_fprev  = 1'b0;
    logic [3:0] m_sprev  = 4'd0;

    // Reference model: battle rules in terms of frame ticks seen and hits taken.
    always @(posedge Clk) begin : model_p
        bit   tk;
        bit   acc;
        exp_t e;
        if (Reset) begin
            m_mode = M_IDLE; m_hp = P_MAX; m_iframe = 0; m_intro = 0; m_fight = 0;
            m_tu = 1'b0; m_tick = 1'b0; m_fprev = 1'b0; m_sprev = 4'd0;
        end else begin
            tk      = m_tick;
            m_tick  = frame_clk && !m_fprev;
            m_fprev = frame_clk;
            if (status == ST_BATTLE && m_sprev != ST_BATTLE) begin
                m_mode = M_INTRO; m_hp = P_MAX; m_iframe = 0;
                m_intro = 0; m_fight = 0; m_tu = 1'b0;
            end else if (m_mode != M_IDLE && status != ST_BATTLE) begin
                m_mode = M_IDLE; m_tu = 1'b0; m_iframe = 0;
            end else begin
                case (m_mode)
                    M_INTRO: if (tk) begin
                        m_intro++;
                        if (m_intro == P_INTRO) m_mode = M_FIGHT;
                    end
                    M_FIGHT: begin
                        acc = hit && (m_iframe == 0);
                        if (acc) begin
                            m_hp     = (m_hp > P_DMG) ? m_hp - P_DMG : 0;
                            m_iframe = P_IFR;
                        end else if (tk && m_iframe > 0) begin
                            m_iframe--;
                        end
                        if (acc && m_hp == 0) begin
                            m_mode = M_DONE;
                        end else if (tk) begin
                            m_fight++;
                            if (m_fight == P_BATTLE) begin
                                m_tu = 1'b1; m_mode = M_DONE;
                            end
                        end
                    end
                    M_DONE: if (tk && m_iframe > 0) m_iframe--;
                    default: ;
                endcase
            end
            m_sprev = status;
        end
        e.hp  = m_hp;
        e.tu  = m_tu;
        e.inv = (m_iframe != 0);
        e.ben = (m_mode == M_FIGHT);
        e.ph  = (m_fight / P_PHASE) % 4;
        sb.push_back(e);
    end

    // Monitor: one expected vector per cycle, compared away from the active edge.
    always @(negedge Clk) begin : mon_p
        exp_t       e;
        logic [8:0] act, req;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            req = {4'(e.hp), e.tu, e.inv, e.ben, 2'(e.ph)};
            act = {HP, time_up, invuln, bullets_en, phase};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL outputs t=%0t: got hp=%0d tu=%0b inv=%0b ben=%0b ph=%0d expected hp=%0d tu=%0b inv=%0b ben=%0b ph=%0d",
                         $time, HP, time_up, invuln, bullets_en, phase, e.hp, e.tu, e.inv, e.ben, e.ph);
            end
        end
    end

    // Frame clock: level toggles with random hold of 2..4 system cycles.
    initial begin : fclk_p
        int hold;
        frame_clk = 1'b0;
        hold      = 2;
        forever begin
            @(negedge Clk);
            if (hold == 0) begin
                frame_clk = ~frame_clk;
                hold      = $urandom_range(1, 3);
            end else begin
                hold--;
            end
        end
    end

    function automatic bit cond(int k);
        case (k)
            0: return m_mode == M_FIGHT;
            1: return m_mode == M_DONE;
            2: return m_mode == M_FIGHT && m_fight >= 100;
            3: return m_hp <= 2;
            4: return m_mode == M_FIGHT && m_fight == P_BATTLE - 1 && m_tick && m_iframe == 0;
            5: return m_mode == M_FIGHT && m_fight >= 40;
            6: return m_mode == M_FIGHT && m_fight >= 10;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(int k, int budget, bit rnd_hit, string name);
        int n = 0;
        while (!cond(k) && n < budget) begin
            if (rnd_hit) hit = ($urandom_range(0, 5) == 0);
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!cond(k)) begin
            errors++;
            $display("FAIL %s: condition reached=0 required=1 after %0d cycles", name, n);
        end
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Reset  = 1'b1;
        status = 4'd0;
        hit    = 1'b0;
        cycles(3);
        Reset  = 1'b0;
        chk("reset_hp", HP, P_MAX);
        chk("reset_ben", bullets_en, 0);
        status = ST_TITLE;
        cycles(4);

        // Clean win; random hits during the intro must be ignored.
        status = ST_BATTLE;
        cycles(1);
        chk("entry_hp", HP, P_MAX);
        wait_for(0, 1000, 1'b1, "intro_to_fight");
        hit = 1'b0;
        chk("intro_hits_ignored", HP, P_MAX);
        wait_for(1, 2500, 1'b0, "win_done");
        chk("win_time_up", time_up, 1);
        chk("win_hp", HP, P_MAX);
        cycles(5);
        status = ST_WIN;
        cycles(2);
        chk("exit_clears_time_up", time_up, 0);

        // Hit held for 100 fight ticks: four windows.
        status = ST_BATTLE;
        wait_for(0, 1000, 1'b0, "b_fight");
        hit = 1'b1;
        wait_for(2, 1500, 1'b0, "b_held_100");
        hit = 1'b0;
        cycles(1);
        chk("held_hit_hp", HP, 2);
        wait_for(1, 1500, 1'b0, "b_done");
        chk("held_hit_time_up", time_up, 1);
        status = ST_LOSE;
        cycles(3);

        // HP=2 with the killing hit on the final tick.
        status = ST_MAP2;
        cycles(2);
        status = ST_BATTLE;
        wait_for(0, 1000, 1'b0, "c_fight");
        hit = 1'b1;
        wait_for(3, 1500, 1'b0, "c_hp2");
        hit = 1'b0;
        wait_for(4, 2500, 1'b0, "c_final_tick");
        hit = 1'b1;
        cycles(1);
        hit = 1'b0;
        chk("final_tick_hp", HP, 0);
        chk("final_tick_time_up", time_up, 0);
        cycles(20);
        chk("final_tick_time_up_stays", time_up, 0);
        status = ST_LOSE;
        cycles(3);

        // Five hits exhaust HP; continued hits must not wrap.
        status = ST_BATTLE;
        hit    = 1'b1;
        wait_for(1, 2500, 1'b0, "d_dead");
        cycles(200);
        hit = 1'b0;
        chk("dead_hp", HP, 0);
        chk("dead_time_up", time_up, 0);
        status = ST_DIALOG;
        cycles(3);

        // Leave mid-fight, return, then reset mid-battle.
        status = ST_BATTLE;
        wait_for(5, 2000, 1'b1, "e_fight40");
        hit    = 1'b1;
        status = ST_WIN;
        cycles(3);
        hit    = 1'b0;
        status = ST_BATTLE;
        cycles(1);
        chk("reentry_hp", HP, P_MAX);
        chk("reentry_phase", phase, 0);
        wait_for(6, 1500, 1'b1, "e_fight10");
        hit   = 1'b0;
        Reset = 1'b1;
        cycles(1);
        Reset = 1'b0;
        chk("midreset_hp", HP, P_MAX);
        chk("midreset_ben", bullets_en, 0);
        wait_for(0, 1000, 1'b0, "e_restart_fight");
        chk("restart_ben", bullets_en, 1);
        cycles(50);
        status = ST_TITLE;
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/battle_ctrl.md
# battle_ctrl

Sequencer for the battle phase of the game. It watches the top-level game status code and, while the game is in battle, runs the battle clock, owns the player HP register, applies damage from bullet hits with an invulnerability window, and schedules bullet-pattern phases. Its `HP` and `time_up` outputs drive the top-level state machine's battle→lose and battle→win transitions. Its `phase`, `bullets_en` and `invuln` outputs drive the bullet generator and the soul sprite.

## Interface
Parameters:
- `MAX_HP`, 4'd10: HP loaded on battle entry.
- `DAMAGE`, 4'd2: HP removed per accepted hit.
- `INTRO_FRAMES`, 60: grace frames before bullets start.
- `BATTLE_FRAMES`, 1800: fight frames to survive (30 s at 60 Hz). Must be ≤ 4095.
- `IFRAMES`, 30: invulnerability frames after an accepted hit.
- `PHASE_FRAMES`, 450: fight frames per bullet-pattern phase.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `status`, in, 4: game status code. 5 = battle.
- `frame_clk`, in, 1: VGA vsync-rate level signal, synchronous to `Clk`.
- `hit`, in, 1: level, high while a bullet overlaps the soul.
- `HP`, out, 4: current player HP.
- `time_up`, out, 1: battle survived.
- `invuln`, out, 1: invulnerability window active (sprite blinks).
- `bullets_en`, out, 1: bullet generator enable.
- `phase`, out, 2: bullet-pattern selector.

## Operation
- **Frame tick:** one-`Clk` pulse on each rising edge of `frame_clk`. Detected by a registered previous-value compare.
- **Battle entry:** detected when `status`==5 and the registered previous `status`≠5. Entry forces the following, regardless of internal state:
  - `HP`←`MAX_HP`, frame counter←0, iframe counter←0, `phase`←0, `time_up`←0.
  - State←INTRO.
- **States:**
  - **IDLE:** outputs hold, except `bullets_en`=0 and `invuln`=0. Left only via battle entry.
  - **INTRO:** count ticks. At `INTRO_FRAMES` ticks, go to FIGHT and clear the counter. Hits are ignored. `bullets_en`=0.
  - **FIGHT:** `bullets_en`=1.
    - Each tick increments the frame counter.
    - `phase` = (counter / `PHASE_FRAMES`) mod 4. Implemented as a separate phase counter that advances and wraps 3→0.
    - At `BATTLE_FRAMES` ticks: `time_up`←1, go to DONE.
  - **DONE:** `bullets_en`=0. `time_up` and `HP` hold.
- **Damage (FIGHT only):**
  - A hit is accepted on a `Clk` cycle with `hit`=1 and iframe counter=0.
  - Accepted hit: `HP`←max(`HP`−`DAMAGE`, 0) (saturating, no wrap), and iframe counter←`IFRAMES`.
  - The iframe counter decrements on ticks. `invuln` = (iframe counter≠0).
- **HP reaches 0:** go to DONE with `time_up`=0. No further damage; frame counting stops.
- **Hit and final tick on the same cycle:** the damage is applied first. If the resulting `HP`=0, `time_up` stays 0; otherwise `time_up`←1.
- **Exit:** `status`≠5 while in INTRO, FIGHT or DONE → IDLE next cycle. `time_up` clears on that transition; `HP` holds its last value.
- **Re-entry** (e.g. lose→map2→battle) re-runs the full entry reset.

## Timing
- Reset values: `HP`=`MAX_HP`, `time_up`=0, `invuln`=0, `bullets_en`=0, `phase`=0, state=IDLE.
- All outputs are registered.
- Frame tick: asserted 1 `Clk` cycle after the `frame_clk` rising edge.
- Accepted hit → `HP` and `invuln` update on the next `Clk` edge.
- Battle entry → INTRO state and `MAX_HP` visible 1 cycle after `status` becomes 5.
- `time_up` rises on the `Clk` edge that consumes tick number `BATTLE_FRAMES` of FIGHT.
- A `hit` held high through a whole invulnerability window costs exactly `DAMAGE` per window. The re-hit is accepted on the first cycle after the iframe counter reaches 0.
- Reset asserted mid-battle: all outputs return to reset values on the next edge, with state=IDLE. If `status` is still 5 afterwards, that counts as a new entry only if the previous-status register (reset to 0) differs. It does, so the battle restarts.

## Structure
- Shared package `game_pkg` holds:
  - Status-code constants `ST_TITLE`=1 through `ST_LOSE`=7, with `ST_BATTLE`=5.
  - The `battle_state_t` enum {IDLE, INTRO, FIGHT, DONE}.
  - `HP_W`=4.
- One sub-module, `frame_edge` (registered rising-edge detector producing the one-cycle tick), is instantiated once.
- Counters: 12-bit frame counter, 9-bit phase counter, 6-bit iframe counter.

## Test plan
- Reset, then `status`=5 → next cycle `HP`=10, INTRO. After 60 ticks `bullets_en`=1, `phase`=0.
- Use `BATTLE_FRAMES`=20, `PHASE_FRAMES`=5 with no hits → `phase` goes 0,1,2,3. `time_up`=1 on tick 20 of FIGHT. `status`→6 clears `time_up`.
- `hit` held high for 100 ticks with `IFRAMES`=30 → HP 10→8→6→4→2 (4 accepted hits, spaced 30 ticks apart).
- 5 accepted hits → `HP`=0, `time_up` never asserts. A 6th hit leaves `HP`=0 (no wrap to 14).
- `HP`=2 with an accepted hit on the final-tick cycle → `HP`=0, `time_up`=0.
- `hit` during INTRO → `HP` stays 10. `status` leaving 5 mid-FIGHT, then returning → `HP` reloads to 10 and `phase` resets to 0.
